// File: rtl/throw_arb_pkg.sv
// throw_arb_pkg: shared state, owner and width definitions for the throw arbiter
package throw_arb_pkg;
  localparam int FORCE_W_DEF = 10;
  typedef enum logic [2:0] {S_IDLE, S_GRANT, S_LAUNCH, S_FLIGHT, S_REPORT, S_COOLDOWN} state_e;
  typedef enum logic {OWNER_DOG = 1'b0, OWNER_CAT = 1'b1} owner_e;
endpackage

// File: rtl/arb_cycle_counter.sv
// arb_cycle_counter: loadable down-counter that holds at zero and flags it
module arb_cycle_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] load_val,
  output logic         zero
);
  logic [W-1:0] cnt;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt <= '0;
    else if (load) cnt <= load_val;
    else if (en && cnt != '0) cnt <= cnt - 1'b1;
  end
  assign zero = (cnt == '0);
endmodule

// File: rtl/throw_arbiter.sv
// throw_arbiter: grants the shared trajectory engine to dog or cat throw requests
// Defining THROW_ARB_TIMEOUT_EN adds a flight watchdog that aborts after TIMEOUT_CYCLES.
module throw_arbiter
  import throw_arb_pkg::*;
#(
  parameter int FORCE_W         = FORCE_W_DEF,
  parameter int MAX_FORCE       = 1000,
  parameter int TIMEOUT_CYCLES  = 260_000_000,
  parameter int COOLDOWN_CYCLES = 65_000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_dog,
  input  logic [FORCE_W-1:0] force_dog,
  input  logic               req_cat,
  input  logic [FORCE_W-1:0] force_cat,
  input  logic               dog_turn,
  input  logic               cat_turn,
  input  logic               eng_busy,
  input  logic               eng_done,
  input  logic               eng_hit,
  output logic               eng_start,
  output logic               eng_sel,
  output logic [FORCE_W-1:0] eng_force,
  output logic               gnt_dog,
  output logic               gnt_cat,
  output logic               done_dog,
  output logic               done_cat,
  output logic               hit_cat,
  output logic               hit_dog,
  output logic               timeout
);
  localparam int CD_W = $clog2(COOLDOWN_CYCLES + 1);
  state_e             state;
  owner_e             win, rr_ptr;
  logic               pend_dog, pend_cat, grant_now, cd_zero, wd_zero;
  logic [FORCE_W-1:0] win_force, sat_force;
  // turn flags break ties first; rr_ptr names the preferred owner when they do not
  assign win = owner_e'(!pend_dog | (pend_cat & ((dog_turn ^ cat_turn) ? cat_turn : rr_ptr)));
  assign grant_now = (state == S_IDLE) && (pend_dog || pend_cat) && !eng_busy;
  assign win_force = (win == OWNER_CAT) ? force_cat : force_dog;
  assign sat_force = (32'(win_force) > MAX_FORCE) ? FORCE_W'(MAX_FORCE) : win_force;
  arb_cycle_counter #(.W(CD_W)) u_cooldown (
    .clk(clk), .rst(rst), .load(state == S_REPORT), .en(state == S_COOLDOWN),
    .load_val(CD_W'(COOLDOWN_CYCLES - 1)), .zero(cd_zero)
  );
`ifdef THROW_ARB_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  arb_cycle_counter #(.W(WD_W)) u_watchdog (
    .clk(clk), .rst(rst), .load(state == S_LAUNCH), .en(state == S_FLIGHT),
    .load_val(WD_W'(TIMEOUT_CYCLES - 1)), .zero(wd_zero)
  );
`else
  assign wd_zero = 1'b0;
`endif
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      pend_dog  <= 1'b0;
      pend_cat  <= 1'b0;
      rr_ptr    <= OWNER_DOG;
      eng_start <= 1'b0;
      eng_sel   <= 1'b0;
      eng_force <= '0;
      gnt_dog   <= 1'b0;
      gnt_cat   <= 1'b0;
      done_dog  <= 1'b0;
      done_cat  <= 1'b0;
      hit_cat   <= 1'b0;
      hit_dog   <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      pend_dog  <= req_dog | (pend_dog & ~(grant_now & (win == OWNER_DOG)));
      pend_cat  <= req_cat | (pend_cat & ~(grant_now & (win == OWNER_CAT)));
      eng_start <= 1'b0;
      done_dog  <= 1'b0;
      done_cat  <= 1'b0;
      hit_cat   <= 1'b0;
      hit_dog   <= 1'b0;
      timeout   <= 1'b0;
      case (state)
        S_IDLE: if (grant_now) begin
          state     <= S_GRANT;
          eng_sel   <= win;
          eng_force <= sat_force;
          gnt_dog   <= (win == OWNER_DOG);
          gnt_cat   <= (win == OWNER_CAT);
          rr_ptr    <= (win == OWNER_DOG) ? OWNER_CAT : OWNER_DOG;
        end
        S_GRANT: begin
          state     <= S_LAUNCH;
          eng_start <= 1'b1;
        end
        S_LAUNCH: state <= S_FLIGHT;
        // a real finish beats a watchdog expiry in the same cycle
        S_FLIGHT: if (eng_done || wd_zero) begin
          state    <= S_REPORT;
          done_dog <= (eng_sel == OWNER_DOG);
          done_cat <= (eng_sel == OWNER_CAT);
          hit_cat  <= eng_done & eng_hit & (eng_sel == OWNER_DOG);
          hit_dog  <= eng_done & eng_hit & (eng_sel == OWNER_CAT);
          timeout  <= !eng_done;
        end
        S_REPORT: begin
          state   <= S_COOLDOWN;
          gnt_dog <= 1'b0;
          gnt_cat <= 1'b0;
        end
        S_COOLDOWN: if (cd_zero) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule
